reg_write_arbiter: RTL and testbench
====================================

// Module: reg_write_arbiter
// PURPOSE
//   Parametrised register-file write-port arbiter; successor to the fixed 16-source, 16-bit "last valid wins" selector.
//   Collects NUM_REQ writeback requests (valid/ready, addr, data) and grants one per cycle by fixed priority or round-robin.
//   Registers the winner into a single valid/ready write stage feeding the register file, and counts collision cycles.
//   Sits between the core's execute/memory writeback sources and the register file write port.
// PARAMETERS
//   NUM_REQ  16  number of requesting sources (>=1)
//   DATA_W   16  write data width
//   ADDR_W   4   register address width
//   MODE     0   0 = fixed priority, highest index wins; 1 = round-robin
//   CNT_W    16  collision counter width (saturating)
// PORTS
//   clk            in   1                 clock; all state on rising edge
//   rst            in   1                 asynchronous, active-low reset
//   req_valid      in   NUM_REQ           per-source write request
//   req_addr       in   NUM_REQ x ADDR_W  per-source destination register
//   req_data       in   NUM_REQ x DATA_W  per-source write data
//   req_ready      out  NUM_REQ           one-hot grant; request accepted when valid & ready
//   default_data   in   DATA_W            value loaded into wr_data when no request is accepted
//   wr_valid       out  1                 output stage holds a write
//   wr_ready       in   1                 register file accepts write
//   wr_addr        out  ADDR_W            registered winning address
//   wr_data        out  DATA_W            registered winning data (default_data when idle)
//   wr_src         out  clog2(NUM_REQ)    index of the source that produced wr_* (0 if NUM_REQ==1)
//   coll_clr       in   1                 synchronous clear of coll_cnt
//   coll_cnt       out  CNT_W             cycles with >=2 requesters while stage loads
// BEHAVIOUR
//   - Reset (rst=0, async): wr_valid=0, wr_addr=0, wr_data=0, wr_src=0, coll_cnt=0, rr pointer=NUM_REQ-1.
//   - load_en = !wr_valid | wr_ready. Output stage loads only when load_en=1; otherwise all wr_* hold.
//   - req_ready[i] = load_en & grant[i]; combinational from req_valid, pointer, wr_valid, wr_ready. At most one bit set.
//   - MODE 0: grant = highest index with req_valid=1.
//   - MODE 1: search starts at (ptr+1) mod NUM_REQ, ascending with wrap; first valid wins.
//     ptr <= granted index only on accept (valid & ready); ptr holds on stall or idle.
//   - Accept: wr_valid<=1, wr_addr/wr_data<=req_*[g], wr_src<=g. Latency request->wr_valid = 1 cycle.
//   - No valid request with load_en=1: wr_valid<=0, wr_data<=default_data, wr_addr<=0, wr_src<=0.
//   - Back-to-back: with wr_ready=1 continuously, one write per cycle, no bubbles.
//   - Stall (wr_valid=1, wr_ready=0): all req_ready=0, wr_* stable, coll_cnt holds.
//     Requesters hold valid/addr/data until accepted.
//   - Collision: when load_en=1 and popcount(req_valid)>=2, coll_cnt increments, saturating at 2^CNT_W-1.
//     coll_clr=1 clears and overrides an increment in the same cycle.
//   - Losing requesters are not dropped; they remain valid and compete next load cycle.
//   - Reset mid-operation: the pending write is discarded (wr_valid=0 immediately); ptr returns to NUM_REQ-1.
//   - NUM_REQ=1: grant = req_valid[0] & load_en; MODE ignored; coll_cnt stays 0.
// STRUCTURE
//   - Package reg_arb_pkg: ARB_FIXED_HI=0, ARB_RR=1 mode constants; typedef arb_mode_t; src index width function.
//   - Sub-module arb_pick: combinational one-hot picker (req vector, start pointer, mode -> one-hot grant + index).
//     The top level holds the output stage, ptr register and collision counter.
// TESTING
//   - Reset: assert rst=0 mid-write -> wr_valid=0, coll_cnt=0 same cycle; first RR grant after release goes to source 0.
//   - MODE 0, NUM_REQ=16, wr_ready=1: req_valid=0x8421 -> req_ready=0x8000; next cycle wr_src=15; coll_cnt=1.
//   - MODE 1, sources 2,5,9 held valid, wr_ready=1 -> grants 2,5,9,2,5 on successive cycles, one write per cycle.
//   - Stall: wr_valid=1, wr_ready=0 for 3 cycles with 0x0003 valid -> req_ready=0, wr_* stable, coll_cnt unchanged.
//     wr_ready=1 -> source 1 granted (MODE 0).
//   - Idle: req_valid=0, default_data=0xBEEF -> wr_valid=0, wr_data=0xBEEF next cycle.
//   - Saturation: CNT_W=2, 5 collision cycles -> coll_cnt=3; coll_clr with a collision -> 0.

Source files
------------

// File: rtl/reg_write_arbiter_pkg.sv
// Shared definitions for the register-file write-port arbiter.
// Provides the arbitration mode encoding and the source-index width helper.
package reg_arb_pkg;

  typedef enum logic {
    ARB_FIXED_HI = 1'b0,
    ARB_RR       = 1'b1
  } arb_mode_t;

  // Source index width; a single source still needs a 1-bit field so wr_src exists.
  function automatic int src_w(input int n);
    return (n > 32'sd1) ? $clog2(n) : 32'sd1;
  endfunction

endpackage

// File: rtl/reg_write_arbiter_if.sv
// Writeback request bus, register-file write stage and collision counter of the arbiter.
interface reg_write_arbiter_if
  import reg_arb_pkg::*;
#(
  parameter int NUM_REQ = 16,
  parameter int DATA_W  = 16,
  parameter int ADDR_W  = 4,
  parameter int CNT_W   = 16
);
  localparam int SRC_W = src_w(NUM_REQ);

  logic [NUM_REQ-1:0]             req_valid;
  logic [NUM_REQ-1:0][ADDR_W-1:0] req_addr;
  logic [NUM_REQ-1:0][DATA_W-1:0] req_data;
  logic [NUM_REQ-1:0]             req_ready;
  logic [DATA_W-1:0]              default_data;
  logic                           wr_valid;
  logic                           wr_ready;
  logic [ADDR_W-1:0]              wr_addr;
  logic [DATA_W-1:0]              wr_data;
  logic [SRC_W-1:0]               wr_src;
  logic                           coll_clr;
  logic [CNT_W-1:0]               coll_cnt;

  modport master (
    output req_valid, req_addr, req_data, default_data, wr_ready, coll_clr,
    input  req_ready, wr_valid, wr_addr, wr_data, wr_src, coll_cnt
  );

  modport slave (
    input  req_valid, req_addr, req_data, default_data, wr_ready, coll_clr,
    output req_ready, wr_valid, wr_addr, wr_data, wr_src, coll_cnt
  );

endinterface

// File: rtl/reg_write_arbiter_pick.sv
// Combinational one-hot picker: walks the requests in priority order and keeps the first hit.
// Fixed mode walks from the highest index down; round-robin walks upward from ptr+1 with wrap.
module arb_pick
  import reg_arb_pkg::*;
#(
  parameter int NUM_REQ = 16,
  parameter int SRC_W   = 4
) (
  input  logic [NUM_REQ-1:0] i_req,
  input  logic [SRC_W-1:0]   i_ptr,
  input  arb_mode_t          i_mode,
  output logic [NUM_REQ-1:0] o_grant,
  output logic [SRC_W-1:0]   o_idx,
  output logic               o_any
);

  logic [SRC_W-1:0] w_sel;
  logic             w_hit;

  // Priority walk; with one source every order collapses to index 0, so MODE has no effect.
  always_comb begin
    o_grant = '0;
    o_idx   = '0;
    o_any   = 1'b0;
    w_sel   = '0;
    w_hit   = 1'b0;
    for (int k = 32'sd1; k <= NUM_REQ; k++) begin
      w_sel = (i_mode == ARB_RR) ? SRC_W'((int'(i_ptr) + k) % NUM_REQ)
                                 : SRC_W'(NUM_REQ - k);
      w_hit          = i_req[w_sel] & ~o_any;
      o_grant[w_sel] = o_grant[w_sel] | w_hit;
      o_idx          = w_hit ? w_sel : o_idx;
      o_any          = o_any | w_hit;
    end
  end

endmodule

// File: rtl/reg_write_arbiter.sv
// Register-file write-port arbiter: picks one writeback source per load cycle into a
// single valid/ready write stage and counts cycles where several sources competed.
module reg_write_arbiter
  import reg_arb_pkg::*;
#(
  parameter int NUM_REQ = 16,
  parameter int DATA_W  = 16,
  parameter int ADDR_W  = 4,
  parameter int MODE    = 0,
  parameter int CNT_W   = 16
) (
  input logic               clk,
  input logic               rst,
  reg_write_arbiter_if.slave bus
);

  localparam int               SRC_W   = src_w(NUM_REQ);
  localparam arb_mode_t        MODE_E  = (MODE == 32'sd1) ? ARB_RR : ARB_FIXED_HI;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [SRC_W-1:0]   r_ptr;
  logic               r_wr_valid;
  logic [ADDR_W-1:0]  r_wr_addr;
  logic [DATA_W-1:0]  r_wr_data;
  logic [SRC_W-1:0]   r_wr_src;
  logic [CNT_W-1:0]   r_coll_cnt;

  logic [NUM_REQ-1:0] w_grant;
  logic [SRC_W-1:0]   w_idx;
  logic               w_any;
  logic               w_load_en;
  logic               w_coll;

  arb_pick #(
    .NUM_REQ (NUM_REQ),
    .SRC_W   (SRC_W)
  ) u_pick (
    .i_req   (bus.req_valid),
    .i_ptr   (r_ptr),
    .i_mode  (MODE_E),
    .o_grant (w_grant),
    .o_idx   (w_idx),
    .o_any   (w_any)
  );

  assign w_load_en     = ~r_wr_valid | bus.wr_ready;
  assign w_coll        = ($countones(bus.req_valid) > 32'sd1);
  assign bus.req_ready = w_grant & {NUM_REQ{w_load_en}};
  assign bus.wr_valid  = r_wr_valid;
  assign bus.wr_addr   = r_wr_addr;
  assign bus.wr_data   = r_wr_data;
  assign bus.wr_src    = r_wr_src;
  assign bus.coll_cnt  = r_coll_cnt;

  // Write stage and round-robin pointer; the pointer only follows accepted grants.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wr_valid <= 1'b0;
      r_wr_addr  <= '0;
      r_wr_data  <= '0;
      r_wr_src   <= '0;
      r_ptr      <= SRC_W'(NUM_REQ - 32'sd1);
    end else if (w_load_en) begin
      if (w_any) begin
        r_wr_valid <= 1'b1;
        r_wr_addr  <= bus.req_addr[w_idx];
        r_wr_data  <= bus.req_data[w_idx];
        r_wr_src   <= w_idx;
        r_ptr      <= w_idx;
      end else begin
        r_wr_valid <= 1'b0;
        r_wr_addr  <= '0;
        r_wr_data  <= bus.default_data;
        r_wr_src   <= '0;
      end
    end
  end

  // Saturating collision counter; clear wins over a same-cycle increment.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_coll_cnt <= '0;
    end else if (bus.coll_clr) begin
      r_coll_cnt <= '0;
    end else if (w_load_en && w_coll && (r_coll_cnt != CNT_MAX)) begin
      r_coll_cnt <= r_coll_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

endmodule

// File: tb/tb_reg_write_arbiter.sv
// Bench for reg_write_arbiter: three instances (fixed 16-way, round-robin 16-way with a 2-bit
// counter, single source) checked every cycle against a behavioural model, plus literal checks.
module tb_reg_write_arbiter;
  import reg_arb_pkg::*;

  logic             clk;
  logic             rst;
  logic [15:0]      tb_req_valid;
  logic [15:0][3:0] tb_req_addr;
  logic [15:0][15:0] tb_req_data;
  logic [15:0]      tb_default;
  logic             tb_wr_ready;
  logic             tb_coll_clr;

  int total = 0;
  int bad   = 0;

  reg_write_arbiter_if #(.NUM_REQ(16), .DATA_W(16), .ADDR_W(4), .CNT_W(16)) if_a ();
  reg_write_arbiter_if #(.NUM_REQ(16), .DATA_W(16), .ADDR_W(4), .CNT_W(2))  if_b ();
  reg_write_arbiter_if #(.NUM_REQ(1),  .DATA_W(16), .ADDR_W(4), .CNT_W(16)) if_c ();

  assign if_a.req_valid = tb_req_valid;    assign if_b.req_valid = tb_req_valid;
  assign if_a.req_addr  = tb_req_addr;     assign if_b.req_addr  = tb_req_addr;
  assign if_a.req_data  = tb_req_data;     assign if_b.req_data  = tb_req_data;
  assign if_a.default_data = tb_default;   assign if_b.default_data = tb_default;
  assign if_a.wr_ready  = tb_wr_ready;     assign if_b.wr_ready  = tb_wr_ready;
  assign if_a.coll_clr  = tb_coll_clr;     assign if_b.coll_clr  = tb_coll_clr;
  assign if_c.req_valid    = tb_req_valid[0];
  assign if_c.req_addr[0]  = tb_req_addr[0];
  assign if_c.req_data[0]  = tb_req_data[0];
  assign if_c.default_data = tb_default;
  assign if_c.wr_ready     = tb_wr_ready;
  assign if_c.coll_clr     = tb_coll_clr;

  reg_write_arbiter #(.NUM_REQ(16), .DATA_W(16), .ADDR_W(4), .MODE(0), .CNT_W(16))
    u_a (.clk(clk), .rst(rst), .bus(if_a));
  reg_write_arbiter #(.NUM_REQ(16), .DATA_W(16), .ADDR_W(4), .MODE(1), .CNT_W(2))
    u_b (.clk(clk), .rst(rst), .bus(if_b));
  reg_write_arbiter #(.NUM_REQ(1),  .DATA_W(16), .ADDR_W(4), .MODE(1), .CNT_W(16))
    u_c (.clk(clk), .rst(rst), .bus(if_c));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference model state per instance: 0 = fixed16, 1 = rr16 (2-bit counter), 2 = single source
  int m_num [3] = '{16, 16, 1};
  int m_mode[3] = '{0, 1, 0};
  int m_max [3] = '{65535, 3, 65535};
  int m_valid[3], m_addr[3], m_data[3], m_src[3], m_cnt[3], m_ptr[3];
  int p_load[3], p_g[3], p_pc[3];

  // Per-cycle compare: predict grant at the falling edge, advance the model at the rising edge.
  initial begin
    forever begin
      @(negedge clk);
      for (int k = 0; k < 3; k++) begin
        logic [31:0] a_rdy, a_val, a_adr, a_dat, a_src, a_cnt, e_rdy, v;
        int g;
        case (k)
          0: begin a_rdy = 32'(if_a.req_ready); a_val = 32'(if_a.wr_valid); a_adr = 32'(if_a.wr_addr);
                   a_dat = 32'(if_a.wr_data); a_src = 32'(if_a.wr_src); a_cnt = 32'(if_a.coll_cnt); end
          1: begin a_rdy = 32'(if_b.req_ready); a_val = 32'(if_b.wr_valid); a_adr = 32'(if_b.wr_addr);
                   a_dat = 32'(if_b.wr_data); a_src = 32'(if_b.wr_src); a_cnt = 32'(if_b.coll_cnt); end
          default: begin a_rdy = 32'(if_c.req_ready); a_val = 32'(if_c.wr_valid); a_adr = 32'(if_c.wr_addr);
                   a_dat = 32'(if_c.wr_data); a_src = 32'(if_c.wr_src); a_cnt = 32'(if_c.coll_cnt); end
        endcase
        if (!rst) begin
          m_valid[k] = 0; m_addr[k] = 0; m_data[k] = 0; m_src[k] = 0; m_cnt[k] = 0;
          m_ptr[k] = m_num[k] - 1;
        end else begin
          v = (m_num[k] == 16) ? 32'(tb_req_valid) : 32'(tb_req_valid[0]);
          p_pc[k]   = $countones(v);
          p_load[k] = (m_valid[k] == 0 || tb_wr_ready) ? 1 : 0;
          g = -1;
          if (m_mode[k] == 1) begin
            for (int i = m_ptr[k] + 1; i < m_num[k]; i++) if (v[i] && g < 0) g = i;
            for (int i = 0; i <= m_ptr[k]; i++) if (v[i] && g < 0) g = i;
          end else begin
            for (int i = 0; i < m_num[k]; i++) if (v[i]) g = i;
          end
          p_g[k] = g;
          e_rdy  = (p_load[k] != 0 && g >= 0) ? (32'd1 << g) : 32'd0;
          chk($sformatf("req_ready[%0d]", k), a_rdy, e_rdy);
        end
        chk($sformatf("wr_valid[%0d]", k), a_val, 32'(m_valid[k]));
        chk($sformatf("wr_addr[%0d]", k),  a_adr, 32'(m_addr[k]));
        chk($sformatf("wr_data[%0d]", k),  a_dat, 32'(m_data[k]));
        chk($sformatf("wr_src[%0d]", k),   a_src, 32'(m_src[k]));
        chk($sformatf("coll_cnt[%0d]", k), a_cnt, 32'(m_cnt[k]));
      end
      @(posedge clk);
      if (rst) begin
        for (int k = 0; k < 3; k++) begin
          if (p_load[k] != 0) begin
            if (p_g[k] >= 0) begin
              m_valid[k] = 1; m_addr[k] = int'(tb_req_addr[p_g[k]]);
              m_data[k] = int'(tb_req_data[p_g[k]]); m_src[k] = p_g[k]; m_ptr[k] = p_g[k];
            end else begin
              m_valid[k] = 0; m_addr[k] = 0; m_data[k] = int'(tb_default); m_src[k] = 0;
            end
          end
          if (tb_coll_clr) m_cnt[k] = 0;
          else if (p_load[k] != 0 && p_pc[k] >= 2 && m_cnt[k] < m_max[k]) m_cnt[k]++;
        end
      end
    end
  end

  int rr_seq[5] = '{2, 5, 9, 2, 5};

  // Directed scenarios with literal expectations, then randomized traffic.
  initial begin
    rst = 1'b0; tb_req_valid = '0; tb_default = '0; tb_wr_ready = 1'b1; tb_coll_clr = 1'b0;
    for (int i = 0; i < 16; i++) begin
      tb_req_addr[i] = 4'(i);
      tb_req_data[i] = 16'h1000 + 16'(i);
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_valid", 32'(if_a.wr_valid), 32'd0);
    chk("reset_cnt", 32'(if_a.coll_cnt), 32'd0);

    step(); rst = 1'b1; tb_req_valid = 16'h8421;
    @(negedge clk); chk("fixed_ready", 32'(if_a.req_ready), 32'h8000);
    step();
    @(negedge clk);
    chk("fixed_src", 32'(if_a.wr_src), 32'd15);
    chk("fixed_cnt", 32'(if_a.coll_cnt), 32'd1);
    chk("fixed_data", 32'(if_a.wr_data), 32'h100f);

    step(); rst = 1'b0;
    @(negedge clk);
    chk("midrst_valid", 32'(if_a.wr_valid), 32'd0);
    chk("midrst_cnt", 32'(if_a.coll_cnt), 32'd0);
    chk("midrst_valid_rr", 32'(if_b.wr_valid), 32'd0);

    step(); rst = 1'b1; tb_req_valid = 16'hffff;
    @(negedge clk); chk("rr_first", 32'(if_b.req_ready), 32'h0001);
    step(); tb_req_valid = 16'h0224;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("rr_grant", 32'(if_b.req_ready), 32'd1 << rr_seq[i]);
      if (i > 0) chk("rr_src", 32'(if_b.wr_src), 32'(rr_seq[i-1]));
      if (i > 0) chk("rr_no_bubble", 32'(if_b.wr_valid), 32'd1);
      step();
    end

    tb_req_valid = 16'h0003; tb_wr_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("stall_ready", 32'(if_a.req_ready), 32'd0);
      chk("stall_src", 32'(if_a.wr_src), 32'd9);
      chk("stall_cnt", 32'(if_a.coll_cnt), 32'd6);
      step();
    end
    tb_wr_ready = 1'b1;
    @(negedge clk); chk("release_ready", 32'(if_a.req_ready), 32'h0002);
    step(); tb_req_valid = 16'h0000; tb_default = 16'hbeef;
    @(negedge clk); chk("release_src", 32'(if_a.wr_src), 32'd1);
    step();
    @(negedge clk);
    chk("idle_valid", 32'(if_a.wr_valid), 32'd0);
    chk("idle_data", 32'(if_a.wr_data), 32'hbeef);

    step(); tb_coll_clr = 1'b1;
    step(); tb_coll_clr = 1'b0; tb_req_valid = 16'h0003;
    repeat (5) step();
    @(negedge clk); chk("sat_cnt", 32'(if_b.coll_cnt), 32'd3);
    step(); tb_coll_clr = 1'b1;
    step(); tb_coll_clr = 1'b0;
    @(negedge clk); chk("clr_override", 32'(if_b.coll_cnt), 32'd0);
    chk("single_cnt", 32'(if_c.coll_cnt), 32'd0);

    for (int n = 0; n < 3000; n++) begin
      step();
      rst = ($urandom_range(0, 199) != 0);
      case ($urandom_range(0, 3))
        0:       tb_req_valid = 16'h0000;
        1:       tb_req_valid = 16'd1 << $urandom_range(0, 15);
        2:       tb_req_valid = 16'($urandom & $urandom);
        default: tb_req_valid = 16'($urandom);
      endcase
      for (int i = 0; i < 16; i++) begin
        tb_req_addr[i] = 4'($urandom);
        tb_req_data[i] = 16'($urandom);
      end
      tb_default  = 16'($urandom);
      tb_wr_ready = ($urandom_range(0, 3) != 0);
      tb_coll_clr = ($urandom_range(0, 31) == 0);
    end

    step(); rst = 1'b1; tb_req_valid = '0; tb_coll_clr = 1'b0;
    repeat (3) step();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
